// File: rtl/audio_pwm_mixer_if.sv
// Voice/strobe/speaker bundle between the sound generators and audio_pwm_mixer.
// Latency: none (wires only).
// Backpressure: none; producers hold Sound/chan_en stable through each clk_44khz cycle.
interface audio_pwm_mixer_if #(
    parameter int CHANNELS = 4,
    parameter int SAMPLE_W = 8
);
    localparam int MW = SAMPLE_W + $clog2(CHANNELS);

    logic [CHANNELS*SAMPLE_W-1:0] Sound;
    logic [CHANNELS-1:0]          chan_en;
    logic                         clk_88khz;
    logic                         clk_44khz;
    logic [MW-1:0]                mix;
    logic                         SPK;

    modport master (
        output Sound,
        output chan_en,
        input  clk_88khz,
        input  clk_44khz,
        input  mix,
        input  SPK
    );

    modport slave (
        input  Sound,
        input  chan_en,
        output clk_88khz,
        output clk_44khz,
        output mix,
        output SPK
    );
endinterface

// File: rtl/audio_pwm_mixer.sv
// Multi-voice audio mixer: fractional-rate sample strobes, summed voices, 1-bit PWM (or sigma-delta with AUDIO_SIGMA_DELTA_EN).
// Latency: mix 1 cycle after clk_44khz; SPK follows at the next PWM wrap plus 1 registered cycle.
// Backpressure: none; inputs are sampled only on the clk_44khz cycle and must be stable then.
module audio_pwm_mixer #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int SAMPLE_HZ = 44_100,
    parameter int CHANNELS  = 4,
    parameter int SAMPLE_W  = 8
) (
    input  logic             Clk,
    input  logic             reset,
    audio_pwm_mixer_if.slave bus
);
    localparam int MW = SAMPLE_W + $clog2(CHANNELS);
    localparam logic [32:0] ACC_STEP  = 33'(2 * SAMPLE_HZ);
    localparam logic [32:0] ACC_LIMIT = 33'(CLK_HZ);

    if ((CHANNELS < 1) || (CHANNELS > 8) || ((CHANNELS & (CHANNELS - 1)) != 0)) begin : g_chan_check
        $error("audio_pwm_mixer: CHANNELS must be a power of two in 1..8");
    end

    // One full PWM period must fit inside one output sample.
    if ((64'd1 << MW) > 64'(CLK_HZ / SAMPLE_HZ)) begin : g_rate_check
        $error("audio_pwm_mixer: 2**MW exceeds CLK_HZ/SAMPLE_HZ");
    end

    logic [31:0]   acc;
    logic [32:0]   acc_sum;
    logic          acc_wrap;
    logic          half;
    logic [MW-1:0] mix_next;
    logic [MW-1:0] pcnt;
    logic [MW-1:0] duty;

    assign acc_sum  = {1'b0, acc} + ACC_STEP;
    assign acc_wrap = (acc_sum >= ACC_LIMIT);

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            acc           <= '0;
            half          <= 1'b0;
            bus.clk_88khz <= 1'b0;
            bus.clk_44khz <= 1'b0;
        end else begin
            bus.clk_88khz <= acc_wrap;
            bus.clk_44khz <= acc_wrap & half;
            if (acc_wrap) begin
                acc  <= 32'(acc_sum - ACC_LIMIT);
                half <= ~half;
            end else begin
                acc  <= acc_sum[31:0];
            end
        end
    end

    // Zero-extended sum cannot overflow: MW carries log2(CHANNELS) guard bits.
    always_comb begin
        mix_next = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (bus.chan_en[k]) begin
                mix_next = mix_next + MW'(bus.Sound[k*SAMPLE_W +: SAMPLE_W]);
            end
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            bus.mix <= '0;
        end else if (bus.clk_44khz) begin
            bus.mix <= mix_next;
        end
    end

    // duty is only reloaded as pcnt rolls over, so each period uses a single value.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            pcnt <= '0;
            duty <= '0;
        end else begin
            pcnt <= pcnt + MW'(1);
            if (&pcnt) begin
                duty <= bus.mix;
            end
        end
    end

`ifdef AUDIO_SIGMA_DELTA_EN
    logic [MW:0] err;
    logic [MW:0] sd_sum;

    assign sd_sum = err + {1'b0, duty};

    // Carry out of the error accumulator gives a pulse density of duty/2**MW.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            err     <= '0;
            bus.SPK <= 1'b0;
        end else begin
            err     <= {1'b0, sd_sum[MW-1:0]};
            bus.SPK <= sd_sum[MW];
        end
    end
`else
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            bus.SPK <= 1'b0;
        end else begin
            bus.SPK <= (pcnt < duty);
        end
    end
`endif

endmodule

// File: tb/tb_audio_pwm_mixer.sv
// Randomised and directed bench for audio_pwm_mixer against an arithmetic reference model.
module tb_audio_pwm_mixer;
    localparam int     CHANNELS = 4;
    localparam int     SAMPLE_W = 8;
    localparam int     MW       = 10;
    localparam int     PER      = 1024;
    localparam longint CLK_HZ   = 50_000_000;
    localparam longint INC      = 88_200;

    logic Clk   = 1'b0;
    logic reset = 1'b1;

    audio_pwm_mixer_if #(.CHANNELS(CHANNELS), .SAMPLE_W(SAMPLE_W)) bus();

    audio_pwm_mixer #(
        .CLK_HZ   (50_000_000),
        .SAMPLE_HZ(44_100),
        .CHANNELS (CHANNELS),
        .SAMPLE_W (SAMPLE_W)
    ) dut (
        .Clk  (Clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int passes = 0;

    // Reference model state, indexed by e = rising edges since reset release.
    longint e;
    int     m_mix;
    int     m_duty;
    bit     m_spk;
    bit     m_88;
    bit     m_44;
    longint m_sd;

    function automatic longint n88_at(longint k);
        return (k * INC) / CLK_HZ;
    endfunction

    function automatic longint edge_of_88(longint n);
        return (n * CLK_HZ + INC - 1) / INC;
    endfunction

    function automatic int vsum(logic [31:0] s, logic [3:0] en);
        int acc;
        acc = 0;
        for (int k = 0; k < CHANNELS; k++)
            if (en[k]) acc += int'(s[k*SAMPLE_W +: SAMPLE_W]);
        return acc;
    endfunction

    function automatic bit model_matches();
        return (bus.SPK === m_spk) && (bus.mix === 10'(m_mix)) &&
               (bus.clk_88khz === m_88) && (bus.clk_44khz === m_44);
    endfunction

    task automatic model_reset();
        e = 0; m_mix = 0; m_duty = 0; m_spk = 0; m_88 = 0; m_44 = 0; m_sd = 0;
    endtask

    task automatic step();
        int     in_sum;
        longint t;
        in_sum = vsum(bus.Sound, bus.chan_en);
        @(posedge Clk);
        e++;
        t = (e - 1) % PER;
`ifdef AUDIO_SIGMA_DELTA_EN
        m_spk = ((m_sd + m_duty) / PER) != (m_sd / PER);
        m_sd  = m_sd + m_duty;
`else
        m_spk = (t < m_duty);
`endif
        if (t == PER - 1) m_duty = m_mix;
        if (m_44) m_mix = in_sum;
        m_88 = n88_at(e) != n88_at(e - 1);
        m_44 = m_88 && (n88_at(e) % 2 == 0);
        @(negedge Clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.Sound = '0;
        bus.chan_en = '0;
        repeat (10) @(negedge Clk);
        checks++; if (bus.SPK !== 1'b0) $display("FAIL reset_spk: got %0b want 0", bus.SPK); else passes++;
        checks++; if (bus.mix !== 10'd0) $display("FAIL reset_mix: got %0d want 0", bus.mix); else passes++;
        checks++; if (bus.clk_88khz !== 1'b0) $display("FAIL reset_88: got %0b want 0", bus.clk_88khz); else passes++;
        checks++; if (bus.clk_44khz !== 1'b0) $display("FAIL reset_44: got %0b want 0", bus.clk_44khz); else passes++;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_strobes();
        longint first88 = -1;
        int n88 = 0, n44 = 0, wide = 0, errs = 0;
        bit p88 = 0, p44 = 0;
        for (int i = 0; i < 15000; i++) begin
            step();
            if (!model_matches()) errs++;
            if (bus.clk_88khz === 1'b1) begin
                n88++;
                if (first88 < 0) first88 = e;
                if (p88) wide++;
            end
            if (bus.clk_44khz === 1'b1) begin
                n44++;
                if (p44) wide++;
            end
            p88 = bus.clk_88khz;
            p44 = bus.clk_44khz;
        end
        checks++; if (first88 != 567) $display("FAIL first_88: got %0d want 567", first88); else passes++;
        checks++; if (n88 != int'(n88_at(e))) $display("FAIL count_88: got %0d want %0d", n88, n88_at(e)); else passes++;
        checks++; if (n44 != int'(n88_at(e) / 2)) $display("FAIL count_44: got %0d want %0d", n44, n88_at(e) / 2); else passes++;
        checks++; if (wide != 0) $display("FAIL strobe_width: got %0d multi-cycle strobes want 0", wide); else passes++;
        checks++; if (errs != 0) $display("FAIL strobe_trace: got %0d mismatching cycles want 0", errs); else passes++;
    endtask

    task automatic test_single_voice();
        int errs = 0, hi = 0;
        bus.Sound = 32'h0000_0031;
        bus.chan_en = 4'b0001;
        for (int i = 0; i < 1500 && !m_44; i++) begin step(); if (!model_matches()) errs++; end
        checks++; if (bus.clk_44khz !== 1'b1) $display("FAIL voice_strobe: got %0b want 1", bus.clk_44khz); else passes++;
        step();
        checks++; if (bus.mix !== 10'd49) $display("FAIL voice_mix: got %0d want 49", bus.mix); else passes++;
        do begin step(); if (!model_matches()) errs++; end while (e % PER != 0);
        for (int i = 0; i < PER; i++) begin
            step();
            if (!model_matches()) errs++;
            if (bus.SPK === 1'b1) hi++;
        end
        checks++; if (hi != 49) $display("FAIL voice_duty: got %0d high cycles want 49", hi); else passes++;
        checks++; if (errs != 0) $display("FAIL voice_trace: got %0d mismatching cycles want 0", errs); else passes++;
    endtask

    task automatic test_mix_enables();
        int errs = 0, exp_mix;
        bus.Sound = 32'hFFFF_FFFF;
        bus.chan_en = 4'hF;
        for (int i = 0; i < 1500 && !m_44; i++) begin step(); if (!model_matches()) errs++; end
        step();
        checks++; if (bus.mix !== 10'd1020) $display("FAIL mix_full: got %0d want 1020", bus.mix); else passes++;
        bus.chan_en = 4'b0101;
        for (int i = 0; i < 1500 && !m_44; i++) begin step(); if (!model_matches()) errs++; end
        step();
        checks++; if (bus.mix !== 10'd510) $display("FAIL mix_en0101: got %0d want 510", bus.mix); else passes++;
        for (int r = 0; r < 5; r++) begin
            bus.Sound = $urandom;
            bus.chan_en = 4'($urandom_range(0, 15));
            exp_mix = vsum(bus.Sound, bus.chan_en);
            for (int i = 0; i < 1500 && !m_44; i++) begin step(); if (!model_matches()) errs++; end
            step();
            checks++; if (bus.mix !== 10'(exp_mix)) $display("FAIL mix_random: got %0d want %0d", bus.mix, exp_mix); else passes++;
        end
        checks++; if (errs != 0) $display("FAIL mix_trace: got %0d mismatching cycles want 0", errs); else passes++;
    endtask

    task automatic test_glitch_free();
        longint k = 0, kprev = 0, w, base;
        bit found = 0;
        int errs = 0, hi_a = 0, hi_b = 0;
        bus.Sound = 32'h0000_0064;
        bus.chan_en = 4'b0001;
        base = n88_at(e);
        // Pick a sample whose mix update lands in the last tenth of a PWM period.
        for (longint j = base + 1; j < base + 400 && !found; j++) begin
            if (j % 2 == 0 && edge_of_88(j) > e + 1200 && ((edge_of_88(j) + 1) % PER) >= 920) begin
                found = 1;
                k = edge_of_88(j);
                kprev = edge_of_88(j - 2);
            end
        end
        if (!found) begin
            checks++;
            $display("FAIL glitch_setup: got no near-wrap sample want one");
            return;
        end
        w = ((k + 1) / PER + 1) * PER;
        while (e < kprev + 1) begin step(); if (!model_matches()) errs++; end
        bus.Sound = 32'h87FF_FFFF;
        bus.chan_en = 4'hF;
        while (e < w - PER) begin step(); if (!model_matches()) errs++; end
        for (int i = 0; i < PER; i++) begin step(); if (!model_matches()) errs++; if (bus.SPK === 1'b1) hi_a++; end
        for (int i = 0; i < PER; i++) begin step(); if (!model_matches()) errs++; if (bus.SPK === 1'b1) hi_b++; end
        checks++; if (hi_a != 100) $display("FAIL glitch_inflight: got %0d high cycles want 100", hi_a); else passes++;
        checks++; if (hi_b != 900) $display("FAIL glitch_next: got %0d high cycles want 900", hi_b); else passes++;
        checks++; if (errs != 0) $display("FAIL glitch_trace: got %0d mismatching cycles want 0", errs); else passes++;
    endtask

    task automatic test_async_reset();
        int errs = 0;
        longint first88 = -1;
        for (int i = 0; i < 3000 && bus.SPK !== 1'b1; i++) step();
        checks++; if (bus.SPK !== 1'b1) $display("FAIL async_pre_spk: got %0b want 1", bus.SPK); else passes++;
        #2;
        reset = 1'b1;
        #1;
        checks++; if (bus.SPK !== 1'b0) $display("FAIL async_spk: got %0b want 0", bus.SPK); else passes++;
        checks++; if (bus.mix !== 10'd0) $display("FAIL async_mix: got %0d want 0", bus.mix); else passes++;
        checks++; if (bus.clk_88khz !== 1'b0 || bus.clk_44khz !== 1'b0)
            $display("FAIL async_strobes: got %0b/%0b want 0/0", bus.clk_88khz, bus.clk_44khz); else passes++;
        repeat (10) @(negedge Clk);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 600; i++) begin
            step();
            if (!model_matches()) errs++;
            if (bus.clk_88khz === 1'b1 && first88 < 0) first88 = e;
        end
        checks++; if (first88 != 567) $display("FAIL async_first_88: got %0d want 567", first88); else passes++;
        checks++; if (errs != 0) $display("FAIL async_trace: got %0d mismatching cycles want 0", errs); else passes++;
    endtask

`ifdef AUDIO_SIGMA_DELTA_EN
    task automatic test_sigma_delta();
        int errs = 0, ones = 0, bad_gap = 0;
        longint last = -1;
        bus.Sound = 32'h0000_01FF;
        bus.chan_en = 4'b0011;
        for (int i = 0; i < 1500 && !m_44; i++) begin step(); if (!model_matches()) errs++; end
        step();
        do begin step(); if (!model_matches()) errs++; end while (e % PER != 0);
        for (int i = 0; i < PER; i++) begin
            step();
            if (!model_matches()) errs++;
            if (bus.SPK === 1'b1) begin
                ones++;
                if (last >= 0 && e - last != 4) bad_gap++;
                last = e;
            end
        end
        checks++; if (ones != 256) $display("FAIL sd_density: got %0d ones want 256", ones); else passes++;
        checks++; if (bad_gap != 0) $display("FAIL sd_spacing: got %0d irregular gaps want 0", bad_gap); else passes++;
        checks++; if (errs != 0) $display("FAIL sd_trace: got %0d mismatching cycles want 0", errs); else passes++;
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_strobes();
        test_single_voice();
        test_mix_enables();
        test_glitch_free();
        test_async_reset();
`ifdef AUDIO_SIGMA_DELTA_EN
        test_sigma_delta();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
